// File: rtl/mcpu_pkg.sv
// -----------------------------------------------------------------------------
// mcpu_pkg
// Shared definitions for the MCPU instruction fetch path.
//   MCPU_WORD_SIZE / MCPU_ADDR_WIDTH : default RAM word and address widths
//   phase_e                          : fetch phase (opcode word / operand word)
//   instr_t                          : one assembled instruction at the
//                                      default widths {opcode, operand, pc}
// -----------------------------------------------------------------------------
package mcpu_pkg;

   localparam int MCPU_WORD_SIZE  = 8;
   localparam int MCPU_ADDR_WIDTH = 8;

   // PH_LO fetches the opcode word, PH_HI fetches the operand word.
   typedef enum logic {
      PH_LO = 1'b0,
      PH_HI = 1'b1
   } phase_e;

   typedef struct packed {
      logic [MCPU_WORD_SIZE-1:0]  opcode;
      logic [MCPU_WORD_SIZE-1:0]  operand;
      logic [MCPU_ADDR_WIDTH-1:0] pc;
   } instr_t;

endpackage

// File: rtl/mcpu_sync_fifo.sv
// -----------------------------------------------------------------------------
// mcpu_sync_fifo
// Single-clock FIFO with a combinational head read.
//   clk, reset : clock, asynchronous active-high reset
//   i_flush    : empties the FIFO on the next edge, overrides push/pop
//   i_push     : write i_din; accepted when not full, or when full together
//                with a pop in the same cycle
//   i_pop      : advance the head; ignored when empty
//   o_dout     : current head entry (meaningful only when !o_empty)
//   o_count    : number of stored entries, 0..DEPTH
//   o_full, o_empty
// DEPTH must be a power of two and at least 2 so the pointers wrap freely.
// -----------------------------------------------------------------------------
module mcpu_sync_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_flush,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_din,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_dout,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic                       o_full,
   output logic                       o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;

   logic w_do_pop;
   logic w_do_push;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_dout  = r_mem[r_rd_ptr];

   // A push into a full FIFO only lands when the head leaves on the same edge.
   assign w_do_pop  = i_pop && !o_empty && !i_flush;
   assign w_do_push = i_push && (!o_full || w_do_pop) && !i_flush;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage carries no reset; the head is only observed through o_empty.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_din;
      end
   end

endmodule

// File: rtl/mcpu_fetch_unit.sv
// -----------------------------------------------------------------------------
// mcpu_fetch_unit
// Instruction fetch stage in front of the RAM controller instruction port.
// Fetches the opcode word and then the operand word from consecutive
// addresses, and queues the assembled instruction for the decoder.
//   clk, reset            : clock, asynchronous active-high reset
//   instraddr             : registered fetch address (fetch_pc)
//   instrrd               : RAM word at instraddr, same cycle
//   redirect, redirect_pc : flush and restart fetching at redirect_pc
//   instr_valid           : FIFO head holds an instruction
//   instr_ready           : decoder takes the head this cycle
//   instr_word, instr_pc  : {opcode, operand} and opcode address of the head,
//                           forced to 0 while instr_valid=0
//   dbg_phase, dbg_count  : fetch phase and FIFO occupancy for observation
//
// Handshake: the head transfers on a rising edge where instr_valid=1,
// instr_ready=1 and redirect=0. instr_valid never depends combinationally on
// instr_ready, and redirect cancels any transfer in its cycle.
// -----------------------------------------------------------------------------
module mcpu_fetch_unit
   import mcpu_pkg::*;
#(
   parameter int                    WORD_SIZE  = MCPU_WORD_SIZE,
   parameter int                    ADDR_WIDTH = MCPU_ADDR_WIDTH,
   parameter int                    FIFO_DEPTH = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                            clk,
   input  logic                            reset,
   output logic [ADDR_WIDTH-1:0]           instraddr,
   input  logic [WORD_SIZE-1:0]            instrrd,
   input  logic                            redirect,
   input  logic [ADDR_WIDTH-1:0]           redirect_pc,
   output logic                            instr_valid,
   input  logic                            instr_ready,
   output logic [2*WORD_SIZE-1:0]          instr_word,
   output logic [ADDR_WIDTH-1:0]           instr_pc,
   output phase_e                          dbg_phase,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] dbg_count
);

   typedef struct packed {
      logic [WORD_SIZE-1:0]  opcode;
      logic [WORD_SIZE-1:0]  operand;
      logic [ADDR_WIDTH-1:0] pc;
   } fetch_instr_t;

   localparam int EW = $bits(fetch_instr_t);

   phase_e                r_phase;
   logic [ADDR_WIDTH-1:0] r_fetch_pc;
   logic [WORD_SIZE-1:0]  r_opcode;
   logic [ADDR_WIDTH-1:0] r_op_pc;

   logic                  w_pop;
   logic                  w_push;
   logic                  w_fetch_en;
   logic                  w_full;
   logic                  w_empty;
   fetch_instr_t          w_push_entry;
   fetch_instr_t          w_head;
   logic [EW-1:0]         w_head_bits;

   assign w_pop = instr_valid && instr_ready && !redirect;

   // The opcode latch sits outside the FIFO, so LO may always proceed.
   // HI needs a free slot, or one being vacated on the same edge.
   assign w_fetch_en = !redirect && ((r_phase == PH_LO) || !w_full || w_pop);
   assign w_push     = (r_phase == PH_HI) && w_fetch_en;

   assign w_push_entry.opcode  = r_opcode;
   assign w_push_entry.operand = instrrd;
   assign w_push_entry.pc      = r_op_pc;

   mcpu_sync_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_flush (redirect),
      .i_push  (w_push),
      .i_din   (w_push_entry),
      .i_pop   (w_pop),
      .o_dout  (w_head_bits),
      .o_count (dbg_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign w_head = fetch_instr_t'(w_head_bits);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_phase    <= PH_LO;
         r_fetch_pc <= RESET_PC;
         r_opcode   <= '0;
         r_op_pc    <= '0;
      end else if (redirect) begin
         r_phase    <= PH_LO;
         r_fetch_pc <= redirect_pc;
      end else if (w_fetch_en) begin
         case (r_phase)
            PH_LO: begin
               r_opcode <= instrrd;
               r_op_pc  <= r_fetch_pc;
               r_phase  <= PH_HI;
            end
            default: begin
               r_phase  <= PH_LO;
            end
         endcase
         // Natural wrap: an opcode at the top address pairs with address 0.
         r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(1);
      end
   end

   assign instraddr   = r_fetch_pc;
   assign dbg_phase   = r_phase;
   assign instr_valid = !w_empty;
   assign instr_word  = instr_valid ? {w_head.opcode, w_head.operand} : '0;
   assign instr_pc    = instr_valid ? w_head.pc : '0;

endmodule

// File: tb/tb_mcpu_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_mcpu_fetch_unit
// Directed scenarios on a RAM holding 0x2C at even and 0x38 at odd addresses,
// then a randomized run on random RAM contents, with random backpressure and
// redirects, against a stream model: from any start address the decoder must
// see instructions at start, start+2, ... (mod 256), each made of the words
// at pc and pc+1.
// -----------------------------------------------------------------------------
module tb_mcpu_fetch_unit;
   import mcpu_pkg::*;

   logic        clk;
   logic        reset;
   logic [7:0]  instraddr;
   logic [7:0]  instrrd;
   logic        redirect;
   logic [7:0]  redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr_word;
   logic [7:0]  instr_pc;
   phase_e      dbg_phase;
   logic [2:0]  dbg_count;

   logic [7:0]  mem [256];
   logic [23:0] exp_q[$];
   logic [7:0]  exp_pc;

   int n_vec;
   int n_err;

   assign instrrd = mem[instraddr];

   mcpu_fetch_unit dut (
      .clk         (clk),
      .reset       (reset),
      .instraddr   (instraddr),
      .instrrd     (instrrd),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr_word  (instr_word),
      .instr_pc    (instr_pc),
      .dbg_phase   (dbg_phase),
      .dbg_count   (dbg_count)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Leaves the bench at a falling edge with reset released and ready set.
   task automatic do_reset(input logic ready);
      reset       = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 8'h00;
      instr_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      instr_ready = ready;
      reset       = 1'b0;
   endtask

   // One rising edge, then return at the following falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic load_pattern();
      for (int i = 0; i < 256; i++) mem[i] = i[0] ? 8'h38 : 8'h2C;
   endtask

   // ---------------- scoreboard ----------------
   task automatic sb_restart(input logic [7:0] start);
      exp_q.delete();
      exp_pc = start;
   endtask

   task automatic sb_top_up();
      while (exp_q.size() < 8) begin
         exp_q.push_back({exp_pc, mem[exp_pc], mem[exp_pc + 8'd1]});
         exp_pc = exp_pc + 8'd2;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset       = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 8'h00;
      instr_ready = 1'b0;
      #1;
      n_vec++; if (instraddr !== 8'h00) begin n_err++; $display("FAIL reset_addr got %h want 00", instraddr); end
      n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", instr_valid); end
      n_vec++; if (instr_word !== 16'h0) begin n_err++; $display("FAIL reset_word got %h want 0000", instr_word); end
      n_vec++; if (instr_pc !== 8'h00) begin n_err++; $display("FAIL reset_pc got %h want 00", instr_pc); end
      n_vec++; if (dbg_phase !== PH_LO) begin n_err++; $display("FAIL reset_phase got %0d want LO", dbg_phase); end
      n_vec++; if (dbg_count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", dbg_count); end
      @(posedge clk);
      #1;
      n_vec++; if (instraddr !== 8'h00 || instr_valid !== 1'b0) begin
         n_err++; $display("FAIL reset_hold addr %h valid %b want 00 0", instraddr, instr_valid);
      end
   endtask

   // Scenario 1: free-running fetch with the decoder always ready.
   task automatic test_stream();
      do_reset(1'b1);
      for (int k = 1; k <= 8; k++) begin
         step();
         n_vec++; if (instraddr !== 8'(k)) begin n_err++; $display("FAIL stream_addr edge %0d got %h want %h", k, instraddr, 8'(k)); end
         n_vec++; if (instr_valid !== ((k % 2) == 0)) begin n_err++; $display("FAIL stream_valid edge %0d got %b", k, instr_valid); end
         if ((k % 2) == 0) begin
            n_vec++; if (instr_word !== 16'h2C38 || instr_pc !== 8'(k - 2)) begin
               n_err++; $display("FAIL stream_head edge %0d got %h@%h want 2c38@%h", k, instr_word, instr_pc, 8'(k - 2));
            end
         end
      end
   endtask

   // Scenarios 2 and 3: fill under backpressure, then pop while full.
   task automatic test_backpressure();
      logic [7:0] pcs [4];
      int         n_pop;
      do_reset(1'b0);
      for (int e = 1; e <= 12; e++) begin
         step();
         if (e == 8) begin
            n_vec++; if (dbg_count !== 3'd4 || dbg_phase !== PH_LO || instraddr !== 8'h08) begin
               n_err++; $display("FAIL bp_full8 count %0d phase %0d addr %h want 4 LO 08", dbg_count, dbg_phase, instraddr);
            end
         end
         if (e >= 9) begin
            n_vec++; if (instraddr !== 8'h09 || dbg_phase !== PH_HI) begin
               n_err++; $display("FAIL bp_stall edge %0d addr %h phase %0d want 09 HI", e, instraddr, dbg_phase);
            end
            n_vec++; if (instr_valid !== 1'b1 || instr_word !== 16'h2C38 || instr_pc !== 8'h00) begin
               n_err++; $display("FAIL bp_head edge %0d got %b %h@%h want 1 2c38@00", e, instr_valid, instr_word, instr_pc);
            end
         end
      end
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      n_vec++; if (dbg_count !== 3'd4 || instr_pc !== 8'h02 || instraddr !== 8'h0A || dbg_phase !== PH_LO) begin
         n_err++; $display("FAIL full_poppush count %0d pc %h addr %h phase %0d want 4 02 0a LO", dbg_count, instr_pc, instraddr, dbg_phase);
      end
      // Drain: the four queued instructions must come out as 02,04,06,08.
      n_pop = 0;
      instr_ready = 1'b1;
      for (int c = 0; c < 20 && n_pop < 4; c++) begin
         if (instr_valid) begin
            pcs[n_pop] = instr_pc;
            n_pop++;
         end
         step();
      end
      instr_ready = 1'b0;
      n_vec++; if (n_pop != 4) begin n_err++; $display("FAIL drain_count got %0d want 4", n_pop); end
      for (int i = 0; i < 4; i++) begin
         n_vec++; if (pcs[i] !== 8'(2 + 2 * i)) begin n_err++; $display("FAIL drain_pc %0d got %h want %h", i, pcs[i], 8'(2 + 2 * i)); end
      end
   endtask

   // Scenario 4: redirect while full, with ready high in the redirect cycle.
   task automatic test_redirect_full();
      do_reset(1'b0);
      repeat (12) step();
      redirect    = 1'b1;
      redirect_pc = 8'h41;
      instr_ready = 1'b1;
      step();
      redirect    = 1'b0;
      instr_ready = 1'b0;
      n_vec++; if (instr_valid !== 1'b0 || dbg_count !== 3'd0 || instr_word !== 16'h0) begin
         n_err++; $display("FAIL redir_flush valid %b count %0d word %h want 0 0 0000", instr_valid, dbg_count, instr_word);
      end
      n_vec++; if (instraddr !== 8'h41 || dbg_phase !== PH_LO) begin
         n_err++; $display("FAIL redir_addr got %h phase %0d want 41 LO", instraddr, dbg_phase);
      end
      step();
      n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL redir_lat1 valid %b want 0", instr_valid); end
      step();
      n_vec++; if (instr_valid !== 1'b1 || instr_word !== 16'h382C || instr_pc !== 8'h41) begin
         n_err++; $display("FAIL redir_head got %b %h@%h want 1 382c@41", instr_valid, instr_word, instr_pc);
      end
   endtask

   // Scenario 5: an instruction straddling the top of the address space.
   task automatic test_wrap();
      redirect    = 1'b1;
      redirect_pc = 8'hFF;
      step();
      redirect = 1'b0;
      step();
      step();
      n_vec++; if (instr_valid !== 1'b1 || instr_word !== 16'h382C || instr_pc !== 8'hFF) begin
         n_err++; $display("FAIL wrap_head got %b %h@%h want 1 382c@ff", instr_valid, instr_word, instr_pc);
      end
      instr_ready = 1'b1;
      step();
      n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL wrap_gap valid %b want 0", instr_valid); end
      step();
      n_vec++; if (instr_valid !== 1'b1 || instr_word !== 16'h382C || instr_pc !== 8'h01) begin
         n_err++; $display("FAIL wrap_next got %b %h@%h want 1 382c@01", instr_valid, instr_word, instr_pc);
      end
      instr_ready = 1'b0;
   endtask

   // Scenario 6: reset asserted mid-cycle takes effect without a clock edge.
   task automatic test_async_reset();
      do_reset(1'b0);
      repeat (3) step();
      n_vec++; if (dbg_phase !== PH_HI || instr_valid !== 1'b1) begin
         n_err++; $display("FAIL areset_pre phase %0d valid %b want HI 1", dbg_phase, instr_valid);
      end
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      n_vec++; if (instr_valid !== 1'b0 || instr_word !== 16'h0 || instr_pc !== 8'h00) begin
         n_err++; $display("FAIL areset_out got %b %h@%h want 0 0000@00", instr_valid, instr_word, instr_pc);
      end
      n_vec++; if (instraddr !== 8'h00 || dbg_phase !== PH_LO) begin
         n_err++; $display("FAIL areset_addr got %h phase %0d want 00 LO", instraddr, dbg_phase);
      end
      @(negedge clk);
      instr_ready = 1'b1;
      reset       = 1'b0;
      step();
      n_vec++; if (instraddr !== 8'h01 || instr_valid !== 1'b0) begin
         n_err++; $display("FAIL areset_r1 addr %h valid %b want 01 0", instraddr, instr_valid);
      end
      step();
      n_vec++; if (instr_valid !== 1'b1 || instr_word !== 16'h2C38 || instr_pc !== 8'h00) begin
         n_err++; $display("FAIL areset_r2 got %b %h@%h want 1 2c38@00", instr_valid, instr_word, instr_pc);
      end
      instr_ready = 1'b0;
   endtask

   // Random RAM, random ready, occasional redirects; every accepted
   // instruction is checked against the stream model.
   task automatic test_random();
      int         n_pop;
      logic [23:0] exp;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      do_reset(1'b0);
      sb_restart(8'h00);
      sb_top_up();
      n_pop = 0;
      for (int c = 0; c < 3000; c++) begin
         instr_ready = ($urandom_range(0, 9) < 6);
         redirect    = ($urandom_range(0, 99) < 3);
         redirect_pc = 8'($urandom);
         if (redirect) begin
            sb_restart(redirect_pc);
         end else if (instr_valid && instr_ready) begin
            exp = exp_q.pop_front();
            n_pop++;
            n_vec++; if ({instr_pc, instr_word} !== exp) begin
               n_err++; $display("FAIL rand_pop cyc %0d got %h@%h want %h@%h", c, instr_word, instr_pc, exp[15:0], exp[23:16]);
            end
         end else if (!instr_valid) begin
            n_vec++; if (instr_word !== 16'h0 || instr_pc !== 8'h00) begin
               n_err++; $display("FAIL rand_gate cyc %0d got %h@%h want 0000@00", c, instr_word, instr_pc);
            end
         end
         sb_top_up();
         step();
      end
      redirect    = 1'b0;
      instr_ready = 1'b0;
      n_vec++; if (n_pop < 300) begin n_err++; $display("FAIL rand_progress pops %0d want >=300", n_pop); end
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      n_vec = 0;
      n_err = 0;
      load_pattern();
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_full();
      test_wrap();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
